// File: rtl/mdpsk_diff_codec.sv
// mdpsk_diff_codec -- parametrised M-ary differential PSK codec (M = 2**BPS).
//   mode=0 encode: symbol deltas  -> absolute phase indices (TX, mapper -> I/Q LUT)
//   mode=1 decode: phase indices  -> symbol deltas          (RX, after slicer)
// Frames start on an SOF beat, which resets the reference phase and latches mode.
// Optional build macro: MDPSK_GRAY_MAP_EN -- Gray coding on the symbol-side ports
// (the internal reference phase always stays binary).
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   mode                              0 = encode, 1 = decode (latched on SOF)
//   s_data/s_valid/s_sof/s_ready      input beat, valid/ready handshake
//   m_data/m_valid/m_sof/m_eof/m_ready output beat, valid/ready handshake
//   frame_err                         one-cycle pulse: SOF accepted mid-frame
//   drop_cnt                          saturating count of beats discarded in IDLE
//   phase_ref                         current reference phase index (debug)
module mdpsk_diff_codec #(
  parameter int BPS       = 2,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mode,
  input  logic [BPS-1:0]   s_data,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  output logic [BPS-1:0]   m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  input  logic             m_ready,
  output logic             frame_err,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [BPS-1:0]   phase_ref
);

  localparam int SC_W = $clog2(FRAME_LEN);
  localparam logic [SC_W-1:0] LAST_IDX = SC_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [SC_W-1:0] sym_cnt;
  logic            mode_q;

  logic            accept;
  logic            mode_eff;
  logic [BPS-1:0]  sym_in;
  logic [BPS-1:0]  ref_eff;
  logic [BPS-1:0]  enc_p;
  logic [BPS-1:0]  dec_d;
  logic [BPS-1:0]  out_bin;
  logic [BPS-1:0]  out_port;
  logic [BPS-1:0]  ref_next;

`ifdef MDPSK_GRAY_MAP_EN
  function automatic logic [BPS-1:0] bin2gray(input logic [BPS-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [BPS-1:0] gray2bin(input logic [BPS-1:0] g);
    logic [BPS-1:0] b;
    b[BPS-1] = g[BPS-1];
    for (int unsigned i = BPS - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction
`endif

  // Single output register: a new beat may enter whenever the slot is empty
  // or is being drained in this same cycle.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  always_comb begin
`ifdef MDPSK_GRAY_MAP_EN
    sym_in = gray2bin(s_data);
`else
    sym_in = s_data;
`endif
    // An SOF beat uses the incoming mode and a zero reference for itself.
    mode_eff = s_sof ? mode : mode_q;
    ref_eff  = s_sof ? '0 : phase_ref;
    enc_p    = ref_eff + sym_in;
    dec_d    = sym_in - ref_eff;
    out_bin  = mode_eff ? dec_d : enc_p;
    ref_next = mode_eff ? sym_in : enc_p;
`ifdef MDPSK_GRAY_MAP_EN
    out_port = bin2gray(out_bin);
`else
    out_port = out_bin;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      phase_ref <= '0;
      sym_cnt   <= '0;
      mode_q    <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      frame_err <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        if (s_sof) begin
          // SOF in ACTIVE aborts the current frame and restarts as a fresh one.
          frame_err <= (state == ACTIVE);
          mode_q    <= mode;
          phase_ref <= ref_next;
          m_data    <= out_port;
          m_valid   <= 1'b1;
          m_sof     <= 1'b1;
          m_eof     <= 1'b0;
          sym_cnt   <= SC_W'(1);
          state     <= ACTIVE;
        end else if (state == IDLE) begin
          if (drop_cnt != '1) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
          end
        end else begin
          phase_ref <= ref_next;
          m_data    <= out_port;
          m_valid   <= 1'b1;
          m_sof     <= 1'b0;
          if (sym_cnt == LAST_IDX) begin
            m_eof   <= 1'b1;
            sym_cnt <= '0;
            state   <= IDLE;
          end else begin
            m_eof   <= 1'b0;
            sym_cnt <= sym_cnt + SC_W'(1);
          end
        end
      end
    end
  end

endmodule
